// File: rtl/vector_checker.sv
// vector_checker: steps an external vector source through NUM_VECTORS
// vectors, waits DUT_LATENCY cycles for the PE under test to settle,
// compares its result with the expected one and accumulates a mismatch
// count and a per-vector failure mask.
// Optional feature: define VECTOR_CHECKER_LOOP_EN to restart the run
// automatically one cycle after DONE.
module vector_checker #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_VECTORS = 8,
    parameter int DUT_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] result_dut,
    input  logic [2*DATA_WIDTH-1:0] result_exp,
    output logic                    change,
    output logic [3:0]              index,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [4:0]              err_count,
    output logic [15:0]             fail_mask
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_VECTORS - 1);
    localparam logic [3:0] LAT_LOAD  = 4'(DUT_LATENCY);
    localparam logic [4:0] ERR_MAX   = 5'd31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COMPARE = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  err_q, err_d;
    logic [15:0] mask_q, mask_d;
    logic        change_q, change_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] fail_set;
    logic        mismatch;

    // One-hot decode of the current index; bits beyond the run length
    // are tied off so they can never be set.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mask
            if (gi < NUM_VECTORS) begin : g_live
                assign fail_set[gi] = (index_q == 4'(gi));
            end else begin : g_dead
                assign fail_set[gi] = 1'b0;
            end
        end
    endgenerate

    assign mismatch = (result_dut != result_exp);

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        index_d  = index_q;
        err_d    = err_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = LAT_LOAD;
                    index_d = 4'd0;
                    err_d   = 5'd0;
                    mask_d  = 16'h0000;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                state_d = ADVANCE;
                if (mismatch) begin
                    err_d  = (err_q == ERR_MAX) ? ERR_MAX : err_q + 5'd1;
                    mask_d = mask_q | fail_set;
                end
            end
            ADVANCE: begin
                if (index_q == LAST_IDX) begin
                    index_d = 4'd0;
                    state_d = DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = SETTLE;
                    cnt_d   = LAT_LOAD;
                end
            end
            DONE: begin
`ifdef VECTOR_CHECKER_LOOP_EN
                state_d = SETTLE;
                cnt_d   = LAT_LOAD;
                index_d = 4'd0;
                err_d   = 5'd0;
                mask_d  = 16'h0000;
`else
                if (!start) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered status outputs track the state being entered.
        change_d = (state_d == ADVANCE);
        busy_d   = (state_d == SETTLE) || (state_d == COMPARE) || (state_d == ADVANCE);
        done_d   = (state_d == DONE);
    end

    // State and output registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            index_q  <= 4'd0;
            err_q    <= 5'd0;
            mask_q   <= 16'h0000;
            change_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            change_q <= change_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign change    = change_q;
    assign index     = index_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;
    assign pass      = (state_q == DONE) && (err_q == 5'd0);

endmodule

// File: tb/tb_vector_checker.sv
// Directed self-checking bench for vector_checker: one main instance with
// DUT_LATENCY=2 and two side instances with DUT_LATENCY=1 and 15, each
// driven by a small model vector source.
module tb_vector_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   fault = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected result for vector i: byte {i,4'he} repeated (index 3 -> 3e3e).
    function automatic logic [15:0] exp_of(input logic [3:0] i);
        logic [7:0] b;
        b = {i, 4'he};
        return {b, b};
    endfunction

    // ---------------- main instance, latency 2 ----------------
    logic [15:0] rd_a, re_a, mask_a;
    logic [3:0]  index_a, src_a;
    logic [4:0]  err_a;
    logic        change_a, busy_a, done_a, pass_a;

    always @(posedge clk)
        if (reset) src_a <= 4'd0;
        else if (change_a) src_a <= (src_a == 4'd7) ? 4'd0 : src_a + 4'd1;

    assign re_a = exp_of(src_a);
    assign rd_a = (fault == 2) ? 16'hffff : ((fault == 1) && (src_a == 4'd3)) ? 16'h0000 : re_a;

    vector_checker #(.DATA_WIDTH(8), .NUM_VECTORS(8), .DUT_LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .start(start), .result_dut(rd_a), .result_exp(re_a),
        .change(change_a), .index(index_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_mask(mask_a)
    );

    // ---------------- latency 1 instance, mismatch at index 3 ----------------
    logic [15:0] rd_b, re_b, mask_b;
    logic [3:0]  index_b, src_b;
    logic [4:0]  err_b;
    logic        change_b, busy_b, done_b, pass_b;

    always @(posedge clk)
        if (reset) src_b <= 4'd0;
        else if (change_b) src_b <= (src_b == 4'd7) ? 4'd0 : src_b + 4'd1;

    assign re_b = exp_of(src_b);
    assign rd_b = (src_b == 4'd3) ? 16'h0000 : re_b;

    vector_checker #(.DATA_WIDTH(8), .NUM_VECTORS(8), .DUT_LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .result_dut(rd_b), .result_exp(re_b),
        .change(change_b), .index(index_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_mask(mask_b)
    );

    // ---------------- latency 15 instance, mismatch at index 6 ----------------
    logic [15:0] rd_c, re_c, mask_c;
    logic [3:0]  index_c, src_c;
    logic [4:0]  err_c;
    logic        change_c, busy_c, done_c, pass_c;

    always @(posedge clk)
        if (reset) src_c <= 4'd0;
        else if (change_c) src_c <= (src_c == 4'd7) ? 4'd0 : src_c + 4'd1;

    assign re_c = exp_of(src_c);
    assign rd_c = (src_c == 4'd6) ? 16'h0000 : re_c;

    vector_checker #(.DATA_WIDTH(8), .NUM_VECTORS(8), .DUT_LATENCY(15)) u_c (
        .clk(clk), .reset(reset), .start(start_b), .result_dut(rd_c), .result_exp(re_c),
        .change(change_c), .index(index_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_mask(mask_c)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if ({index_a, busy_a, done_a, pass_a, change_a} !== 8'h00) begin
            nfail++; $display("FAIL reset_ctrl idx/busy/done/pass/change got %h want 00",
                              {index_a, busy_a, done_a, pass_a, change_a});
        end
        nvec++; if (err_a !== 5'd0) begin nfail++; $display("FAIL reset_err got %0d want 0", err_a); end
        nvec++; if (mask_a !== 16'h0000) begin nfail++; $display("FAIL reset_mask got %h want 0000", mask_a); end
        $display("reset: index=%0d busy=%b done=%b pass=%b err=%0d mask=%h", index_a, busy_a, done_a, pass_a, err_a, mask_a);
    endtask

    // Full run on the main instance with the given fault mode and expectations.
    task automatic run_a(input int f, input logic [4:0] want_err, input logic [15:0] want_mask,
                         input logic want_pass, input string name);
        int n_chg;
        int last;
        fault = f;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chg = 0;
        last = -1;
        for (int k = 0; k < 400 && !done_a; k++) begin
            if (change_a) begin
                nvec++; if (!busy_a) begin nfail++; $display("FAIL %s change_without_busy", name); end
                if (last >= 0) begin
                    nvec++; if (cyc - last != 4) begin
                        nfail++; $display("FAIL %s period got %0d want 4", name, cyc - last);
                    end
                end
                last = cyc;
                n_chg++;
            end
            @(negedge clk);
        end
        nvec++; if (done_a !== 1'b1) begin nfail++; $display("FAIL %s done_timeout got %b want 1", name, done_a); end
        nvec++; if (n_chg != 8) begin nfail++; $display("FAIL %s change_count got %0d want 8", name, n_chg); end
        nvec++; if (err_a !== want_err) begin nfail++; $display("FAIL %s err_count got %0d want %0d", name, err_a, want_err); end
        nvec++; if (mask_a !== want_mask) begin nfail++; $display("FAIL %s fail_mask got %h want %h", name, mask_a, want_mask); end
        nvec++; if (pass_a !== want_pass) begin nfail++; $display("FAIL %s pass got %b want %b", name, pass_a, want_pass); end
        nvec++; if (index_a !== 4'd0 || src_a !== 4'd0) begin
            nfail++; $display("FAIL %s end_index got %0d/%0d want 0/0", name, index_a, src_a);
        end
        $display("%s: changes=%0d err=%0d mask=%h pass=%b", name, n_chg, err_a, mask_a, pass_a);
    endtask

    task automatic test_match();
        run_a(0, 5'd0, 16'h0000, 1'b1, "match");
    endtask

    task automatic test_single_mismatch();
        run_a(1, 5'd1, 16'h0008, 1'b0, "mismatch_idx3");
    endtask

    task automatic test_stuck();
        run_a(2, 5'd8, 16'h00ff, 1'b0, "stuck_ffff");
    endtask

    task automatic test_reset_mid();
        int k;
        fault = 0;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 100 && index_a != 4'd5; k++) @(negedge clk);
        nvec++; if (index_a !== 4'd5 || !busy_a) begin
            nfail++; $display("FAIL reset_mid reach_idx5 got %0d want 5", index_a);
        end
        reset = 1'b1;
        nvec++; if (change_a !== 1'b0) begin nfail++; $display("FAIL reset_mid change_in_reset_cycle got %b want 0", change_a); end
        @(negedge clk);
        nvec++; if ({index_a, busy_a, done_a, pass_a, change_a, err_a, mask_a} !== 29'd0 || src_a !== 4'd0) begin
            nfail++; $display("FAIL reset_mid outputs got idx=%0d busy=%b done=%b change=%b src=%0d want all 0",
                              index_a, busy_a, done_a, change_a, src_a);
        end
        reset = 1'b0;
        $display("reset_mid: aborted at index 5, outputs cleared");
        run_a(0, 5'd0, 16'h0000, 1'b1, "after_reset");
    endtask

    task automatic test_held_start();
        int n_chg;
        do_reset();
`ifdef VECTOR_CHECKER_LOOP_EN
        fault = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && !done_a; k++) @(negedge clk);
        nvec++; if (done_a !== 1'b1 || err_a !== 5'd8) begin
            nfail++; $display("FAIL loop first_run done/err got %b/%0d want 1/8", done_a, err_a);
        end
        @(negedge clk);
        nvec++; if (busy_a !== 1'b1 || err_a !== 5'd0 || done_a !== 1'b0) begin
            nfail++; $display("FAIL loop restart busy/err/done got %b/%0d/%b want 1/0/0", busy_a, err_a, done_a);
        end
        $display("held_start(loop): restart busy=%b err=%0d", busy_a, err_a);
`else
        fault = 0;
        start = 1'b1;
        for (int k = 0; k < 400 && !done_a; k++) @(negedge clk);
        nvec++; if (done_a !== 1'b1) begin nfail++; $display("FAIL held done_timeout got %b want 1", done_a); end
        n_chg = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (change_a || busy_a) n_chg++;
        end
        nvec++; if (n_chg != 0 || done_a !== 1'b1 || pass_a !== 1'b1) begin
            nfail++; $display("FAIL held no_retrigger activity=%0d done=%b pass=%b want 0/1/1", n_chg, done_a, pass_a);
        end
        start = 1'b0;
        @(negedge clk);
        nvec++; if (done_a !== 1'b0 || pass_a !== 1'b0) begin
            nfail++; $display("FAIL held to_idle done/pass got %b/%b want 0/0", done_a, pass_a);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvec++; if (busy_a !== 1'b1 || err_a !== 5'd0) begin
            nfail++; $display("FAIL held rerun busy/err got %b/%0d want 1/0", busy_a, err_a);
        end
        $display("held_start: stayed in DONE while start high, rerun busy=%b", busy_a);
`endif
    endtask

    task automatic test_latency();
        int nb, nc, lb, lc;
        logic seen_b, seen_c;
        logic [4:0] eb, ec;
        logic [15:0] mb, mc;
        logic pb, pc;
        do_reset();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        nb = 0; nc = 0; lb = -1; lc = -1;
        seen_b = 1'b0; seen_c = 1'b0;
        eb = '0; ec = '0; mb = '0; mc = '0; pb = 1'b0; pc = 1'b0;
        for (int k = 0; k < 400 && !(seen_b && seen_c); k++) begin
            if (change_b && !seen_b) begin
                if (lb >= 0) begin
                    nvec++; if (cyc - lb != 3) begin nfail++; $display("FAIL lat1 period got %0d want 3", cyc - lb); end
                end
                lb = cyc; nb++;
            end
            if (change_c && !seen_c) begin
                if (lc >= 0) begin
                    nvec++; if (cyc - lc != 17) begin nfail++; $display("FAIL lat15 period got %0d want 17", cyc - lc); end
                end
                lc = cyc; nc++;
            end
            if (done_b && !seen_b) begin seen_b = 1'b1; eb = err_b; mb = mask_b; pb = pass_b; end
            if (done_c && !seen_c) begin seen_c = 1'b1; ec = err_c; mc = mask_c; pc = pass_c; end
            @(negedge clk);
        end
        nvec++; if (!seen_b || nb != 8 || eb !== 5'd1 || mb !== 16'h0008 || pb !== 1'b0) begin
            nfail++; $display("FAIL lat1 result done=%b changes=%0d err=%0d mask=%h pass=%b want 1/8/1/0008/0",
                              seen_b, nb, eb, mb, pb);
        end
        nvec++; if (!seen_c || nc != 8 || ec !== 5'd1 || mc !== 16'h0040 || pc !== 1'b0) begin
            nfail++; $display("FAIL lat15 result done=%b changes=%0d err=%0d mask=%h pass=%b want 1/8/1/0040/0",
                              seen_c, nc, ec, mc, pc);
        end
        $display("latency: L1 changes=%0d err=%0d mask=%h, L15 changes=%0d err=%0d mask=%h", nb, eb, mb, nc, ec, mc);
    endtask

    initial begin
        test_reset();
        test_match();
        test_single_mismatch();
        test_stuck();
        test_reset_mid();
        test_latency();
        test_held_start();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
